// File: rtl/aes_pp_pkg.sv
// Shared definitions for the ping-pong AES block memory.
//   bank_state_e : per-bank ownership code reported in STATUS
//   CSR_*        : CSR offsets, selected by the low two address bits in CSR space
//   ERR_BIT      : STATUS bit that carries the sticky error flag
package aes_pp_pkg;

    typedef enum logic [1:0] {
        BANK_IDLE   = 2'd0,
        BANK_QUEUED = 2'd1,
        BANK_BUSY   = 2'd2,
        BANK_DONE   = 2'd3
    } bank_state_e;

    localparam logic [1:0] CSR_STATUS = 2'd0;
    localparam logic [1:0] CSR_COMMIT = 2'd1;
    localparam logic [1:0] CSR_ACK    = 2'd2;
    localparam logic [1:0] CSR_CTRL   = 2'd3;

    localparam int ERR_BIT = 31;

    // The host owns a bank while it is being filled (IDLE) or drained (DONE).
    function automatic logic host_may_access(input bank_state_e s);
        return (s == BANK_IDLE) || (s == BANK_DONE);
    endfunction

endpackage

// File: rtl/aes_pp_bank_queue.sv
// Commit-order FIFO of bank indices.
//   clk, reset : clock, asynchronous active-high reset (queue empties)
//   push       : enqueue push_idx
//   pop        : drop the head entry (caller guarantees non-empty)
//   empty      : no entries held
//   head       : oldest entry
// DEPTH equals the bank count, so a bank queued at most once can never overflow it.
module aes_pp_bank_queue #(
    parameter int DEPTH = 2,
    parameter int IW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [IW-1:0] push_idx,
    input  logic          pop,
    output logic          empty,
    output logic [IW-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] slot_q [DEPTH];
    logic [IW-1:0] slot_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        slot_d  = slot_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (push) begin
            slot_d[wr_q] = push_idx;
            wr_d         = bump(wr_q);
        end
        if (pop) begin
            rd_d = bump(rd_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    assign empty = (count_q == '0);
    assign head  = slot_q[rd_q];

endmodule

// File: rtl/aes_pingpong_block_ram.sv
// Multi-bank AES block memory with per-bank host/engine ownership.
//   clk, reset                 : clock, asynchronous active-high reset
//   address .. writedata       : Avalon slave s1 (address MSB=1 selects CSR space)
//   readdata, readdatavalid    : read response, exactly one cycle after the read
//   eng_start_valid/bank/ready : hands committed banks to the engine in commit order
//   eng_done                   : engine finished the busy bank
//   eng_address/write/...      : engine word port into the busy bank
//   irq                        : irq_en & any bank DONE, registered
// Optional feature macro: AES_PP_IRQ_EN (adds irq port and CTRL.irq_en).
// RAM contents are deliberately not reset.
module aes_pingpong_block_ram
    import aes_pp_pkg::*;
#(
    parameter int    DATA_W    = 128,
    parameter int    DEPTH     = 4,
    parameter int    NUM_BANKS = 2,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(NUM_BANKS * DEPTH) + 1,
    localparam int   BW        = $clog2(NUM_BANKS),
    localparam int   DW        = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AW-1:0]       address,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                eng_start_valid,
    output logic [BW-1:0]       eng_start_bank,
    input  logic                eng_start_ready,
    input  logic                eng_done,
    input  logic [DW-1:0]       eng_address,
    input  logic                eng_write,
    input  logic [DATA_W-1:0]   eng_writedata,
    output logic [DATA_W-1:0]   eng_readdata
`ifdef AES_PP_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int IXW    = AW - 1;
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [NUM_BANKS * DEPTH];

    bank_state_e       bank_state_q [NUM_BANKS];
    bank_state_e       bank_state_d [NUM_BANKS];
    logic              err_q, err_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] eng_readdata_q, eng_readdata_d;
`ifdef AES_PP_IRQ_EN
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
`endif

    logic              is_csr, host_wr, host_rd, host_ok;
    logic [1:0]        csr_sel;
    logic [IXW-1:0]    host_idx;
    logic [BW-1:0]     host_bank;
    logic [2:0]        cmd_idx;
    logic              any_busy, any_done;
    logic [BW-1:0]     busy_bank;
    logic [IXW-1:0]    eng_idx;
    logic              q_push, q_pop, q_empty;
    logic [BW-1:0]     q_head;
    logic              err_set, err_clr;
    logic [DATA_W-1:0] status;

    assign is_csr    = address[AW-1];
    assign csr_sel   = address[1:0];
    assign host_idx  = address[IXW-1:0];
    assign host_bank = address[IXW-1:DW];
    assign host_wr   = chipselect & write;
    assign host_rd   = chipselect & read;
    assign cmd_idx   = writedata[2:0];
    assign eng_idx   = {busy_bank, eng_address};

    // Bank field values beyond NUM_BANKS (non power-of-two counts) are never accessible.
    always_comb begin
        host_ok   = 1'b0;
        any_busy  = 1'b0;
        any_done  = 1'b0;
        busy_bank = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (host_bank == BW'(b)) begin
                host_ok = host_may_access(bank_state_q[b]);
            end
            if (bank_state_q[b] == BANK_BUSY) begin
                any_busy  = 1'b1;
                busy_bank = BW'(b);
            end
            if (bank_state_q[b] == BANK_DONE) begin
                any_done = 1'b1;
            end
        end
    end

    aes_pp_bank_queue #(
        .DEPTH (NUM_BANKS),
        .IW    (BW)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (q_push),
        .push_idx (cmd_idx[BW-1:0]),
        .pop      (q_pop),
        .empty    (q_empty),
        .head     (q_head)
    );

    // Only one bank may be BUSY, so a new start waits for the previous done.
    assign eng_start_valid = !q_empty && !any_busy;
    assign eng_start_bank  = q_head;
    assign q_pop           = eng_start_valid && eng_start_ready;

    // Bank ownership transitions. Host commands, start and done always touch
    // banks in different states, so they never collide on the same bank.
    always_comb begin
        bank_state_d = bank_state_q;
        q_push       = 1'b0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        if (host_wr && !is_csr && !host_ok) begin
            err_set = 1'b1;
        end
        if (host_wr && is_csr) begin
            case (csr_sel)
                CSR_COMMIT: begin
                    err_set = 1'b1;
                    for (int b = 0; b < NUM_BANKS; b++) begin
                        if (cmd_idx == 3'(b) && bank_state_q[b] == BANK_IDLE) begin
                            bank_state_d[b] = BANK_QUEUED;
                            q_push          = 1'b1;
                            err_set         = 1'b0;
                        end
                    end
                end
                CSR_ACK: begin
                    err_set = 1'b1;
                    for (int b = 0; b < NUM_BANKS; b++) begin
                        if (cmd_idx == 3'(b) && bank_state_q[b] == BANK_DONE) begin
                            bank_state_d[b] = BANK_IDLE;
                            err_set         = 1'b0;
                        end
                    end
                end
                CSR_CTRL: err_clr = writedata[1];
                default:  err_clr = 1'b0;
            endcase
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (q_pop && q_head == BW'(b)) begin
                bank_state_d[b] = BANK_BUSY;
            end
            if (eng_done && bank_state_q[b] == BANK_BUSY) begin
                bank_state_d[b] = BANK_DONE;
            end
        end
        err_d = err_clr ? 1'b0 : (err_q | err_set);
    end

    // Read responses for both ports; forbidden or bank-less reads return zero.
    always_comb begin
        status = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            status[2*b +: 2] = bank_state_q[b];
        end
        status[ERR_BIT] = err_q;

        readdata_d = readdata_q;
        rvalid_d   = host_rd;
        if (host_rd) begin
            if (is_csr) begin
                case (csr_sel)
                    CSR_STATUS: readdata_d = status;
`ifdef AES_PP_IRQ_EN
                    CSR_CTRL:   readdata_d = DATA_W'(irq_en_q);
`endif
                    default:    readdata_d = '0;
                endcase
            end else begin
                readdata_d = host_ok ? mem[host_idx] : '0;
            end
        end

        eng_readdata_d = any_busy ? mem[eng_idx] : '0;
    end

`ifdef AES_PP_IRQ_EN
    always_comb begin
        irq_en_d = irq_en_q;
        if (host_wr && is_csr && csr_sel == CSR_CTRL) begin
            irq_en_d = writedata[0];
        end
        irq_d = irq_en_q & any_done;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state_q[b] <= BANK_IDLE;
            end
            err_q          <= 1'b0;
            readdata_q     <= '0;
            rvalid_q       <= 1'b0;
            eng_readdata_q <= '0;
`ifdef AES_PP_IRQ_EN
            irq_en_q       <= 1'b0;
            irq_q          <= 1'b0;
`endif
        end else begin
            bank_state_q   <= bank_state_d;
            err_q          <= err_d;
            readdata_q     <= readdata_d;
            rvalid_q       <= rvalid_d;
            eng_readdata_q <= eng_readdata_d;
`ifdef AES_PP_IRQ_EN
            irq_en_q       <= irq_en_d;
            irq_q          <= irq_d;
`endif
        end
    end

    // True dual-port RAM: exclusive ownership keeps the two write ports apart.
    always_ff @(posedge clk) begin
        if (host_wr && !is_csr && host_ok) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byteenable[i]) begin
                    mem[host_idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
        if (eng_write && any_busy) begin
            mem[eng_idx] <= eng_writedata;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rvalid_q;
    assign eng_readdata  = eng_readdata_q;
`ifdef AES_PP_IRQ_EN
    assign irq           = irq_q;
`endif

endmodule

// File: tb/tb_aes_pingpong_block_ram.sv
// Directed bench for aes_pingpong_block_ram at default parameters
// (DATA_W=128, DEPTH=4, NUM_BANKS=2). Address map: RAM word = {0, bank, word},
// CSR = 8 + offset. The irq checks are compiled only with AES_PP_IRQ_EN.
module tb_aes_pingpong_block_ram;

    localparam logic [3:0] A_STATUS = 4'd8;
    localparam logic [3:0] A_COMMIT = 4'd9;
    localparam logic [3:0] A_ACK    = 4'd10;
    localparam logic [3:0] A_CTRL   = 4'd11;

    localparam logic [127:0] D0  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D1  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D2  = 128'hCAFEBABE_DEADBEEF_0BADF00D_FEEDFACE;
    localparam logic [127:0] D3  = 128'h33333333_33333333_33333333_33333333;
    localparam logic [127:0] P3  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF;
    localparam logic [127:0] D3P = 128'h33333333_33333333_33333333_DEADBEEF;
    localparam logic [127:0] E4  = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   address;
    logic         chipselect, write, read;
    logic [15:0]  byteenable;
    logic [127:0] writedata;
    logic [127:0] readdata;
    logic         readdatavalid;
    logic         eng_start_valid;
    logic [0:0]   eng_start_bank;
    logic         eng_start_ready;
    logic         eng_done;
    logic [1:0]   eng_address;
    logic         eng_write;
    logic [127:0] eng_writedata;
    logic [127:0] eng_readdata;
`ifdef AES_PP_IRQ_EN
    logic         irq;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        bit           wr;
        logic [3:0]   addr;
        logic [127:0] data;
        logic [15:0]  be;
        string        name;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    aes_pingpong_block_ram dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .chipselect      (chipselect),
        .write           (write),
        .read            (read),
        .byteenable      (byteenable),
        .writedata       (writedata),
        .readdata        (readdata),
        .readdatavalid   (readdatavalid),
        .eng_start_valid (eng_start_valid),
        .eng_start_bank  (eng_start_bank),
        .eng_start_ready (eng_start_ready),
        .eng_done        (eng_done),
        .eng_address     (eng_address),
        .eng_write       (eng_write),
        .eng_writedata   (eng_writedata),
        .eng_readdata    (eng_readdata)
`ifdef AES_PP_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    function automatic logic [127:0] a5(input int i);
        return {16{8'hA5}} ^ 128'(i);
    endfunction

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [127:0] d, input logic [15:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        chipselect = 1'b1;
        write      = 1'b1;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [3:0] a, input logic [127:0] exp);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        n_vec++;
        if (readdatavalid !== 1'b1 || readdata !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h valid=%b, expected %h valid=1", name, readdata, readdatavalid, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.wr) host_write(v.addr, v.data, v.be);
        else      check_read(v.name, v.addr, v.data);
    endtask

    task automatic handshake();
        eng_start_ready = 1'b1;
        tick();
        eng_start_ready = 1'b0;
    endtask

    task automatic done_pulse();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
    endtask

    task automatic eng_read_check(input string name, input logic [1:0] a, input logic [127:0] exp);
        eng_address = a;
        tick();
        check_output(name, eng_readdata, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd0,     D0,       16'hFFFF, "load_w0"};
        vecs[1]  = '{1'b1, 4'd1,     D1,       16'hFFFF, "load_w1"};
        vecs[2]  = '{1'b1, 4'd2,     D2,       16'hFFFF, "load_w2"};
        vecs[3]  = '{1'b1, 4'd3,     D3,       16'hFFFF, "load_w3"};
        vecs[4]  = '{1'b1, 4'd3,     P3,       16'h000F, "partial_w3"};
        vecs[5]  = '{1'b1, 4'd4,     E4,       16'hFFFF, "load_b1w0"};
        vecs[6]  = '{1'b0, 4'd0,     D0,       16'h0000, "rd_w0"};
        vecs[7]  = '{1'b0, 4'd1,     D1,       16'h0000, "rd_w1"};
        vecs[8]  = '{1'b0, 4'd2,     D2,       16'h0000, "rd_w2"};
        vecs[9]  = '{1'b0, 4'd3,     D3P,      16'h0000, "rd_w3_bytelanes"};
        vecs[10] = '{1'b0, 4'd4,     E4,       16'h0000, "rd_b1w0"};
        vecs[11] = '{1'b1, 4'd4,     ONES,     16'h0000, "no_lane_write"};
        vecs[12] = '{1'b0, 4'd4,     E4,       16'h0000, "rd_b1w0_no_lanes"};
        vecs[13] = '{1'b0, A_COMMIT, 128'h0,   16'h0000, "rd_unused_csr"};
        vecs[14] = '{1'b1, A_COMMIT, 128'h0,   16'hFFFF, "commit0"};
        vecs[15] = '{1'b0, A_STATUS, 128'h1,   16'h0000, "status_queued"};
        vecs[16] = '{1'b0, 4'd0,     128'h0,   16'h0000, "rd_queued_bank_zero"};
        vecs[17] = '{1'b0, A_STATUS, 128'h1,   16'h0000, "status_no_err_on_read"};

        reset = 1'b1;
        address = '0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        byteenable = '0; writedata = '0;
        eng_start_ready = 1'b0; eng_done = 1'b0; eng_address = '0;
        eng_write = 1'b0; eng_writedata = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check_output("reset_readdatavalid", readdatavalid, 1'b0);
        check_output("reset_readdata", readdata, '0);
        check_output("reset_eng_readdata", eng_readdata, '0);
        check_output("reset_start_valid", eng_start_valid, 1'b0);
`ifdef AES_PP_IRQ_EN
        check_output("reset_irq", irq, 1'b0);
`endif
        check_read("reset_status", A_STATUS, 128'h0);

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Hand bank0 to the engine and let it read and overwrite the block.
        check_output("start_valid_b0", eng_start_valid, 1'b1);
        check_output("start_bank_b0", eng_start_bank, 1'b0);
        handshake();
        check_read("status_busy", A_STATUS, 128'h2);
        check_output("start_valid_while_busy", eng_start_valid, 1'b0);
        eng_read_check("eng_rd_w0", 2'd0, D0);
        eng_read_check("eng_rd_w1", 2'd1, D1);
        eng_read_check("eng_rd_w2", 2'd2, D2);
        eng_read_check("eng_rd_w3", 2'd3, D3P);
        for (int i = 0; i < 4; i++) begin
            eng_address   = 2'(i);
            eng_write     = 1'b1;
            eng_writedata = a5(i);
            tick();
        end
        eng_write = 1'b0;
        eng_read_check("eng_rd_back_w1", 2'd1, a5(1));
        done_pulse();
        check_read("status_done", A_STATUS, 128'h3);
        eng_read_check("eng_rd_no_busy", 2'd0, 128'h0);
        check_read("host_rd_result_w0", 4'd0, a5(0));
        check_read("host_rd_result_w3", 4'd3, a5(3));
        host_write(A_ACK, 128'h0, 16'hFFFF);
        check_read("status_after_ack", A_STATUS, 128'h0);

        // An engine write with no busy bank must not land anywhere.
        eng_address   = 2'd0;
        eng_writedata = ONES;
        eng_write     = 1'b1;
        tick();
        eng_write = 1'b0;
        check_read("eng_wr_dropped", 4'd0, a5(0));

        // Commit 1 in the same cycle bank0 is popped; order must be kept.
        host_write(A_COMMIT, 128'h0, 16'hFFFF);
        eng_start_ready = 1'b1;
        host_write(A_COMMIT, 128'h1, 16'hFFFF);
        eng_start_ready = 1'b0;
        check_read("status_push_pop", A_STATUS, 128'h6);
        check_output("start_blocked_by_busy", eng_start_valid, 1'b0);
        done_pulse();
        check_output("start_valid_b1", eng_start_valid, 1'b1);
        check_output("start_bank_b1", eng_start_bank, 1'b1);
        check_read("status_done_queued", A_STATUS, 128'h7);
        handshake();
        check_read("status_b1_busy", A_STATUS, 128'hB);

        // Error flag: set by forbidden writes and illegal commands, cleared by CTRL bit1.
        host_write(4'd4, ONES, 16'hFFFF);
        check_read("err_busy_write", A_STATUS, 128'h8000000B);
        host_write(A_CTRL, 128'h2, 16'hFFFF);
        check_read("err_cleared", A_STATUS, 128'hB);
        host_write(A_ACK, 128'h1, 16'hFFFF);
        check_read("err_ack_busy", A_STATUS, 128'h8000000B);
        host_write(A_CTRL, 128'h2, 16'hFFFF);
        host_write(A_ACK, 128'h0, 16'hFFFF);
        check_read("status_ack0", A_STATUS, 128'h8);
        host_write(A_COMMIT, 128'h5, 16'hFFFF);
        check_read("err_commit_range", A_STATUS, 128'h80000008);
        host_write(A_CTRL, 128'h2, 16'hFFFF);
        host_write(A_ACK, 128'h0, 16'hFFFF);
        check_read("err_ack_idle", A_STATUS, 128'h80000008);
        host_write(A_CTRL, 128'h2, 16'hFFFF);
        check_read("err_cleared_again", A_STATUS, 128'h8);
        done_pulse();
        check_read("status_b1_done", A_STATUS, 128'hC);
        check_read("busy_write_dropped", 4'd4, E4);

        host_write(A_CTRL, 128'h1, 16'hFFFF);
`ifdef AES_PP_IRQ_EN
        check_read("ctrl_irq_en", A_CTRL, 128'h1);
        check_output("irq_on", irq, 1'b1);
        host_write(A_ACK, 128'h1, 16'hFFFF);
        check_output("irq_lags_ack", irq, 1'b1);
        tick();
        check_output("irq_off", irq, 1'b0);
`else
        check_read("ctrl_reads_zero", A_CTRL, 128'h0);
        host_write(A_ACK, 128'h1, 16'hFFFF);
`endif
        check_read("status_all_idle", A_STATUS, 128'h0);
`ifdef AES_PP_IRQ_EN
        host_write(A_COMMIT, 128'h1, 16'hFFFF);
        handshake();
        done_pulse();
        check_output("irq_lags_done", irq, 1'b0);
        tick();
        check_output("irq_after_done", irq, 1'b1);
        check_read("status_irq_b1_done", A_STATUS, 128'hC);
`endif

        // Reset in the middle of operation empties the queue.
        host_write(A_COMMIT, 128'h0, 16'hFFFF);
        check_output("start_valid_pre_reset", eng_start_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_output("start_valid_post_reset", eng_start_valid, 1'b0);
        check_read("status_post_reset", A_STATUS, 128'h0);
`ifdef AES_PP_IRQ_EN
        check_output("irq_post_reset", irq, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
